result_drain: RTL and testbench

Downstream drain stage of the polynomial evaluation accelerator. It pops the per-instruction status FIFO and, for successful instructions, the matching entry from the result FIFO. Each status/result pair is presented to the output sink over a valid/ready handshake. The block keeps saturating completion and error counters for the bench and top level.

---
 rtl/result_drain.sv | 113 +++++++++++
 tb/tb_result_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Drain stage: pops a status entry, and for OK statuses the matching result entry,
// presents the record over valid/ready, and keeps saturating completion/error counters.
module result_drain #(
  parameter int DATA_WIDTH   = 32,
  parameter int STATUS_WIDTH = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    empty_status,
  input  logic [STATUS_WIDTH-1:0] status_in,
  output logic                    read_enable_status,
  input  logic                    empty_result,
  input  logic [DATA_WIDTH-1:0]   result_in,
  output logic                    read_enable_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [STATUS_WIDTH-1:0] out_status,
  output logic [COUNT_WIDTH-1:0]  done_count,
  output logic [COUNT_WIDTH-1:0]  error_count,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE, POP_S, CAP_S, WAIT_R, POP_R, CAP_R, PRESENT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    re_s_q, re_s_d;
  logic                    re_r_q, re_r_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;
  logic [COUNT_WIDTH-1:0]  done_q, done_d;
  logic [COUNT_WIDTH-1:0]  err_q, err_d;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      IDLE:    if (!empty_status) state_d = POP_S;
      POP_S:   state_d = CAP_S;
      CAP_S: begin
        status_d = status_in;
        if (status_in == '0) begin
          state_d = WAIT_R;
        end else begin
          result_d = '0;
          state_d  = PRESENT;
        end
      end
      WAIT_R:  if (!empty_result) state_d = POP_R;
      POP_R:   state_d = CAP_R;
      CAP_R: begin
        result_d = result_in;
        state_d  = PRESENT;
      end
      PRESENT: if (out_ready) begin
        if (done_q != CNT_MAX) done_d = done_q + CNT_ONE;
        if (status_q != '0 && err_q != CNT_MAX) err_d = err_q + CNT_ONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered, Moore-style.
    re_s_d  = (state_d == POP_S);
    re_r_d  = (state_d == POP_R);
    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      re_s_q   <= 1'b0;
      re_r_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      re_s_q   <= re_s_d;
      re_r_q   <= re_r_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      status_q <= status_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign read_enable_status = re_s_q;
  assign read_enable_result = re_r_q;
  assign out_valid          = valid_q;
  assign out_result         = result_q;
  assign out_status         = status_q;
  assign done_count         = done_q;
  assign error_count        = err_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: queue-based FIFO models, a record scoreboard with
// counter model, and directed cycle-exact vectors; a COUNT_WIDTH=2 copy shows saturation.
module tb_result_drain;
  localparam int DW = 32;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          empty_status = 1'b1;
  logic          empty_result = 1'b1;
  logic [SW-1:0] status_in = '0;
  logic [DW-1:0] result_in = '0;
  logic          out_ready = 1'b0;

  logic          re_s, re_r, ov, busy;
  logic [DW-1:0] ores;
  logic [SW-1:0] osts;
  logic [15:0]   done_c, err_c;

  logic          re_s_b, re_r_b, ov_b, busy_b;
  logic [DW-1:0] ores_b;
  logic [SW-1:0] osts_b;
  logic [1:0]    done_b, err_b;

  result_drain #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .empty_status(empty_status), .status_in(status_in), .read_enable_status(re_s),
    .empty_result(empty_result), .result_in(result_in), .read_enable_result(re_r),
    .out_valid(ov), .out_ready(out_ready), .out_result(ores), .out_status(osts),
    .done_count(done_c), .error_count(err_c), .busy(busy)
  );

  result_drain #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset),
    .empty_status(empty_status), .status_in(status_in), .read_enable_status(re_s_b),
    .empty_result(empty_result), .result_in(result_in), .read_enable_result(re_r_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_result(ores_b), .out_status(osts_b),
    .done_count(done_b), .error_count(err_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] r;
    logic [SW-1:0] s;
  } rec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [SW-1:0] sq[$];
  logic [DW-1:0] rq[$];
  rec_t          exp_q[$];
  int            m_done = 0;
  int            m_err  = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  function automatic longint sat(input int v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : longint'(v);
  endfunction

  task automatic push_status(input logic [SW-1:0] s);
    sq.push_back(s);
    empty_status = 1'b0;
  endtask

  task automatic push_result(input logic [DW-1:0] r);
    rq.push_back(r);
    empty_result = 1'b0;
  endtask

  // Expected record: error statuses always carry a zero result.
  task automatic expect_rec(input logic [DW-1:0] r, input logic [SW-1:0] s);
    rec_t e;
    e.r = (s == '0) ? r : '0;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !ov; i++) @(negedge clock);
    chk({name, "_valid_seen"}, ov, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // FIFO models plus scoreboard, all on the falling edge so nothing races the DUT.
  logic          prev_v = 1'b0, prev_acc = 1'b0, prev_re_s = 1'b0, prev_re_r = 1'b0;
  logic [DW-1:0] prev_res = '0;
  logic [SW-1:0] prev_sts = '0;

  always @(negedge clock) begin
    logic acc;
    rec_t e;
    if (!reset) begin
      chk("rst_valid", ov, 0);
      chk("rst_re_s", re_s, 0);
      chk("rst_re_r", re_r, 0);
      chk("rst_result", ores, 0);
      chk("rst_status", osts, 0);
      chk("rst_done", done_c, 0);
      chk("rst_err", err_c, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_sat", done_b, 0);
      m_done = 0; m_err = 0;
      prev_v = 1'b0; prev_acc = 1'b0; prev_re_s = 1'b0; prev_re_r = 1'b0;
    end else begin
      chk("done_count", done_c, sat(m_done, 16));
      chk("error_count", err_c, sat(m_err, 16));
      chk("done_count_sat", done_b, sat(m_done, 2));
      chk("error_count_sat", err_b, sat(m_err, 2));
      if (prev_v && !prev_acc) begin
        chk("stall_valid", ov, 1);
        chk("stall_result", ores, prev_res);
        chk("stall_status", osts, prev_sts);
      end
      if (re_s) begin
        chk("re_status_one_cycle", prev_re_s, 0);
        chk("pop_status_nonempty", sq.size() != 0, 1);
        if (sq.size() != 0) status_in = sq.pop_front();
        empty_status = (sq.size() == 0);
      end
      if (re_r) begin
        chk("re_result_one_cycle", prev_re_r, 0);
        chk("pop_result_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) result_in = rq.pop_front();
        empty_result = (rq.size() == 0);
      end
      acc = ov && out_ready;
      if (acc) begin
        chk("record_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rec_result", ores, e.r);
          chk("rec_status", osts, e.s);
          chk("rec_sat_valid", ov_b, 1);
          chk("rec_sat_result", ores_b, e.r);
          chk("rec_sat_status", osts_b, e.s);
          m_done++;
          if (e.s != '0) m_err++;
        end
      end
      prev_v = ov; prev_acc = acc; prev_res = ores; prev_sts = osts;
      prev_re_s = re_s; prev_re_r = re_r;
    end
  end

  initial begin
    // Reset held with both FIFOs already non-empty.
    out_ready = 1'b1;
    push_status(2'd0); push_result(32'h15); expect_rec(32'h15, 2'd0);
    repeat (3) @(negedge clock);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("ok_c%0d_valid", c), ov, c == 6);
      chk($sformatf("ok_c%0d_re_s", c), re_s, c == 1);
      chk($sformatf("ok_c%0d_re_r", c), re_r, c == 4);
      chk($sformatf("ok_c%0d_busy", c), busy, c <= 6);
      if (c == 6) begin
        chk("ok_result", ores, 32'h15);
        chk("ok_status", osts, 0);
      end
    end
    chk("ok_done", done_c, 1);
    chk("ok_err", err_c, 0);

    // Error record, result FIFO empty.
    @(posedge clock); #1 push_status(2'd2); expect_rec(32'h0, 2'd2);
    @(posedge clock);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("err_c%0d_valid", c), ov, c == 3);
      chk($sformatf("err_c%0d_re_s", c), re_s, c == 1);
      chk($sformatf("err_c%0d_re_r", c), re_r, 0);
      if (c == 3) begin
        chk("err_result", ores, 0);
        chk("err_status", osts, 2);
      end
    end
    chk("err_done", done_c, 2);
    chk("err_err", err_c, 1);

    // Late result plus backpressure.
    out_ready = 1'b0;
    @(posedge clock); #1 push_status(2'd0); expect_rec(32'h1234_5678, 2'd0);
    @(posedge clock);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("late_c%0d_valid", c), ov, 0);
      chk($sformatf("late_c%0d_re_r", c), re_r, 0);
      chk($sformatf("late_c%0d_busy", c), busy, 1);
    end
    @(posedge clock); #1 push_result(32'h1234_5678);
    wait_valid("late", 20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("late_stall_result", ores, 32'h1234_5678);
      chk("late_stall_done", done_c, 2);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("late_done", done_c, 3);
    chk("late_valid_after", ov, 0);

    // Mixed stream from a clean reset, then saturation of the narrow counters.
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    push_status(2'd0); push_status(2'd1); push_status(2'd0); push_status(2'd3);
    push_result(32'd7); push_result(32'd9);
    expect_rec(32'd7, 2'd0); expect_rec(32'd0, 2'd1);
    expect_rec(32'd9, 2'd0); expect_rec(32'd0, 2'd3);
    wait_drain("mix", 100);
    @(negedge clock);
    chk("mix_done", done_c, 4);
    chk("mix_err", err_c, 2);
    chk("mix_done_sat", done_b, 3);
    chk("mix_err_sat", err_b, 2);
    @(posedge clock); #1 push_status(2'd1); push_status(2'd2);
    expect_rec(32'd0, 2'd1); expect_rec(32'd0, 2'd2);
    wait_drain("sat", 50);
    @(negedge clock);
    chk("sat_done", done_c, 6);
    chk("sat_err", err_c, 4);
    chk("sat_done_hold", done_b, 3);
    chk("sat_err_hold", err_b, 3);

    // Reset while a record is being presented.
    out_ready = 1'b0;
    @(posedge clock); #1 push_status(2'd0); push_status(2'd0);
    push_result(32'hA); push_result(32'hB);
    expect_rec(32'hA, 2'd0); expect_rec(32'hB, 2'd0);
    wait_valid("midrst", 20);
    chk("midrst_result", ores, 32'hA);
    @(posedge clock); #1 reset = 1'b0;
    #1;
    chk("midrst_valid_drop", ov, 0);
    chk("midrst_done", done_c, 0);
    chk("midrst_result_clr", ores, 0);
    void'(exp_q.pop_front());
    repeat (2) @(posedge clock);
    #1 reset = 1'b1; out_ready = 1'b1;
    wait_drain("midrst", 50);
    @(negedge clock);
    chk("midrst_done_after", done_c, 1);
    chk("midrst_sq_empty", sq.size(), 0);
    chk("midrst_rq_empty", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
